// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_channel
//  Description : Multi-channel PWM generator sharing one period counter.
//                Period and per-channel duty are written into shadow
//                registers and reach the active registers only at a period
//                boundary. Edge- or center-aligned counting, saturating
//                duty stepping and per-channel enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel #(
    parameter  int NUM_CH         = 4,
    parameter  int CNT_W          = 10,
    parameter  int STEP           = 1,
    parameter  int DEF_PERIOD     = 1000,
    parameter  int CENTER_ALIGNED = 0,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pwm_en,
    input  logic              period_wr,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              duty_wr,
    input  logic [CH_W-1:0]   duty_ch,
    input  logic [CNT_W-1:0]  duty_in,
    input  logic              up,
    input  logic              down,
    output logic [NUM_CH-1:0] pwm,
    output logic              period_start
);

    localparam logic [CNT_W:0]   c_STEP       = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] c_DEF_PERIOD = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] c_MIN_PERIOD = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_dir_down;
    logic [CNT_W-1:0]  r_period_act;
    logic [CNT_W-1:0]  r_period_sh;
    logic [CNT_W-1:0]  r_duty_act [NUM_CH];
    logic [CNT_W-1:0]  r_duty_sh  [NUM_CH];
    logic [NUM_CH-1:0] r_en_act;
    logic [NUM_CH-1:0] r_pwm;
    logic              r_period_start;

    logic [CNT_W-1:0]  w_period_m1;
    logic              w_wrap;
    logic              w_turn;
    logic              w_ch_valid;
    logic [CNT_W-1:0]  w_period_sh_nxt;
    logic [CNT_W-1:0]  w_duty_sh_nxt [NUM_CH];

    // Saturating increment: the result never exceeds the period shadow.
    function automatic logic [CNT_W-1:0] f_step_up(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] lim);
        logic [CNT_W:0] s;
        s = {1'b0, d} + c_STEP;
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[CNT_W-1:0];
    endfunction

    // Saturating decrement: the result never wraps below zero.
    function automatic logic [CNT_W-1:0] f_step_down(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        if ({1'b0, d} < c_STEP) begin
            return '0;
        end
        s = {1'b0, d} - c_STEP;
        return s[CNT_W-1:0];
    endfunction

    assign w_period_m1 = r_period_act - c_ONE;
    assign w_ch_valid  = (int'(duty_ch) < NUM_CH);

    // Period boundary detection; center mode also flags the top turn-around.
    always_comb begin
        w_wrap = 1'b0;
        w_turn = 1'b0;
        if (CENTER_ALIGNED != 0) begin
            w_turn = !r_dir_down && (r_cnt >= w_period_m1);
            w_wrap = r_dir_down && (r_cnt == '0);
        end else begin
            w_wrap = (r_cnt >= w_period_m1);
        end
    end

    // Next shadow values; the boundary load uses these so a write landing in
    // the wrap cycle is part of that same load.
    always_comb begin
        w_period_sh_nxt = r_period_sh;
        if (period_wr) begin
            w_period_sh_nxt = (period_in < c_MIN_PERIOD) ? c_MIN_PERIOD : period_in;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            w_duty_sh_nxt[i] = r_duty_sh[i];
            if (w_ch_valid && (CH_W'(i) == duty_ch)) begin
                if (duty_wr) begin
                    w_duty_sh_nxt[i] = duty_in;
                end else if (up && !down) begin
                    // Saturate against the shadow as it stood before this clock.
                    w_duty_sh_nxt[i] = f_step_up(r_duty_sh[i], r_period_sh);
                end else if (down && !up) begin
                    w_duty_sh_nxt[i] = f_step_down(r_duty_sh[i]);
                end
            end
        end
    end

    // Shadow registers follow their next values every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_sh <= c_DEF_PERIOD;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= '0;
            end
        end else begin
            r_period_sh <= w_period_sh_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= w_duty_sh_nxt[i];
            end
        end
    end

    // Period counter, boundary load of active registers and enable tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_dir_down     <= 1'b0;
            r_period_act   <= c_DEF_PERIOD;
            r_en_act       <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_act[i] <= '0;
            end
        end else begin
            r_period_start <= w_wrap;
            if (w_wrap) begin
                r_cnt        <= '0;
                r_dir_down   <= 1'b0;
                r_period_act <= w_period_sh_nxt;
                r_en_act     <= pwm_en;
                for (int i = 0; i < NUM_CH; i++) begin
                    r_duty_act[i] <= w_duty_sh_nxt[i];
                end
            end else begin
                // A dropped enable clears the channel until the next boundary.
                r_en_act <= r_en_act & pwm_en;
                if (w_turn) begin
                    r_dir_down <= 1'b1;
                end else if (r_dir_down) begin
                    r_cnt <= r_cnt - c_ONE;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end
        end
    end

    // Registered compare outputs, gated by both active and live enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pwm[i] <= r_en_act[i] & pwm_en[i] & (r_cnt < r_duty_act[i]);
            end
        end
    end

    assign pwm          = r_pwm;
    assign period_start = r_period_start;

endmodule
`default_nettype wire
